// File: rtl/bdram_port_ctrl.sv
// CPU-to-block-RAM port controller: one outstanding request, sub-word writes, fixed 2-cycle response.
// Optional alignment checking is enabled by defining BDRAM_CTRL_ALIGN_CHK_EN.
module bdram_port_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [15:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // valid and its payload are held by the source until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        legal;
    logic [3:0]  we_mask;
    logic [31:0] wdata_rep;
    logic [31:0] rd_ext;
    logic [15:0] addr_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        wr_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        rerr_q;
    logic        unused_addr_hi;

    // Upper address bits alias onto the 256 KiB window.
    assign unused_addr_hi = ^req_addr[31:18];

    assign req_ready = (state_q == IDLE) && !rst;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef BDRAM_CTRL_ALIGN_CHK_EN
    always_comb begin
        legal = 1'b0;
        case (req_size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = !req_addr[0];
            2'b10:   legal = (req_addr[1:0] == 2'b00);
            default: legal = 1'b0;
        endcase
    end
`else
    assign legal = (req_size != 2'b11);
`endif

    always_comb begin
        we_mask   = 4'b0000;
        wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                we_mask   = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                we_mask   = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                we_mask   = 4'b1111;
                wdata_rep = req_wdata;
            end
            default: begin
                we_mask   = 4'b0000;
                wdata_rep = req_wdata;
            end
        endcase
    end

    assign ram_en    = accept && legal;
    assign ram_we    = (accept && legal && req_wr) ? we_mask : 4'b0000;
    assign ram_addr  = accept ? req_addr[17:2] : addr_q;
    assign ram_wdata = wdata_rep;

    // Lane extraction uses the latched request, since RAM data arrives one cycle after accept.
    always_comb begin
        rd_ext = 32'd0;
        case (size_q)
            2'b00: begin
                case (lane_q)
                    2'd0:    rd_ext = {24'd0, ram_rdata[7:0]};
                    2'd1:    rd_ext = {24'd0, ram_rdata[15:8]};
                    2'd2:    rd_ext = {24'd0, ram_rdata[23:16]};
                    default: rd_ext = {24'd0, ram_rdata[31:24]};
                endcase
            end
            2'b01:   rd_ext = lane_q[1] ? {16'd0, ram_rdata[31:16]} : {16'd0, ram_rdata[15:0]};
            2'b10:   rd_ext = ram_rdata;
            default: rd_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= 16'd0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= req_addr[17:2];
                lane_q <= req_addr[1:0];
                size_q <= req_size;
                wr_q   <= req_wr;
                err_q  <= !legal;
            end
            if (state_q == WAIT) begin
                rerr_q  <= err_q;
                rdata_q <= (err_q || wr_q) ? 32'd0 : rd_ext;
            end
        end
    end

endmodule

// File: tb/tb_bdram_port_ctrl.sv
// Directed bench for bdram_port_ctrl with a behavioural byte-enabled RAM (registered read).
// Expectations follow BDRAM_CTRL_ALIGN_CHK_EN when the bench is built with that macro.
module tb_bdram_port_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'd0;
    logic [1:0]  dbg_state;

    logic [31:0] mem [0:255] = '{default: 32'd0};

    int tests = 0;
    int fails = 0;

    bdram_port_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one request and completes the accept edge; leaves the DUT in WAIT.
    task automatic send(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_en, input logic [3:0] exp_we,
                        input logic [31:0] exp_wdata, input logic [15:0] exp_raddr,
                        input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({31'd0, req_ready}, 32'd1, {tag, " req_ready"});
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        check({31'd0, ram_en}, {31'd0, exp_en}, {tag, " ram_en"});
        check({28'd0, ram_we}, {28'd0, exp_we}, {tag, " ram_we"});
        if (exp_en) check({16'd0, ram_addr}, {16'd0, exp_raddr}, {tag, " ram_addr"});
        if (exp_en && wr) check(ram_wdata, exp_wdata, {tag, " ram_wdata"});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        check({30'd0, dbg_state}, 32'd1, {tag, " state WAIT"});
        check({31'd0, rsp_valid}, 32'd0, {tag, " rsp_valid in WAIT"});
        check({31'd0, ram_en}, 32'd0, {tag, " ram_en in WAIT"});
    endtask

    // Expects the response exactly one cycle after WAIT, then takes it.
    task automatic recv(input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        @(posedge clk);
        #1;
        check({31'd0, rsp_valid}, 32'd1, {tag, " rsp_valid"});
        check(rsp_rdata, exp_rdata, {tag, " rsp_rdata"});
        check({31'd0, rsp_err}, {31'd0, exp_err}, {tag, " rsp_err"});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({31'd0, rsp_valid}, 32'd0, {tag, " rsp_valid after take"});
        check({31'd0, req_ready}, 32'd1, {tag, " req_ready after take"});
    endtask

    initial begin
        // Reset state
        #1;
        check({31'd0, rsp_valid}, 32'd0, "rst rsp_valid");
        check(rsp_rdata, 32'd0, "rst rsp_rdata");
        check({31'd0, rsp_err}, 32'd0, "rst rsp_err");
        check({31'd0, ram_en}, 32'd0, "rst ram_en");
        check({28'd0, ram_we}, 32'd0, "rst ram_we");
        check({16'd0, ram_addr}, 32'd0, "rst ram_addr");
        check({30'd0, dbg_state}, 32'd0, "rst state");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check({31'd0, req_ready}, 32'd1, "req_ready after release");

        // Word write then read
        send(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 16'h0004, "wr word");
        recv(32'd0, 1'b0, "wr word");
        check(mem[4], 32'hDEADBEEF, "mem after word write");
        send(1'b0, 2'b10, 32'h10, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0004, "rd word");
        recv(32'hDEADBEEF, 1'b0, "rd word");

        // Byte write over zero and readbacks
        send(1'b1, 2'b10, 32'h10, 32'h0, 1'b1, 4'b1111, 32'h0, 16'h0004, "clr word");
        recv(32'd0, 1'b0, "clr word");
        send(1'b1, 2'b00, 32'h13, 32'h000000A5, 1'b1, 4'b1000, 32'hA5A5A5A5, 16'h0004, "wr byte");
        recv(32'd0, 1'b0, "wr byte");
        send(1'b0, 2'b10, 32'h10, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0004, "rd word after byte");
        recv(32'hA5000000, 1'b0, "rd word after byte");
        send(1'b0, 2'b00, 32'h13, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0004, "rd byte");
        recv(32'h000000A5, 1'b0, "rd byte");

        // Half write to upper lane, readback, byte lane, aliased address
        send(1'b1, 2'b01, 32'h16, 32'hFFFF1234, 1'b1, 4'b1100, 32'h12341234, 16'h0005, "wr half");
        recv(32'd0, 1'b0, "wr half");
        send(1'b0, 2'b01, 32'h16, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0005, "rd half");
        recv(32'h00001234, 1'b0, "rd half");
        send(1'b0, 2'b00, 32'h17, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0005, "rd byte lane3");
        recv(32'h00000012, 1'b0, "rd byte lane3");
        send(1'b0, 2'b01, 32'hFFFC0016, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0005, "rd half alias");
        recv(32'h00001234, 1'b0, "rd half alias");

        // Response backpressure
        send(1'b0, 2'b10, 32'h10, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0004, "bp rd");
        req_valid = 1'b1;
        req_addr  = 32'h20;
        req_size  = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check({31'd0, rsp_valid}, 32'd1, "bp rsp_valid held");
            check(rsp_rdata, 32'hA5000000, "bp rsp_rdata held");
            check({31'd0, req_ready}, 32'd0, "bp req_ready");
            check({31'd0, ram_en}, 32'd0, "bp ram_en");
            check({16'd0, ram_addr}, 32'h0004, "bp ram_addr held");
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({30'd0, dbg_state}, 32'd0, "bp IDLE after take");
        check({31'd0, req_ready}, 32'd1, "bp req_ready after take");

        // Misaligned accesses
        send(1'b1, 2'b10, 32'h20, 32'h11223344, 1'b1, 4'b1111, 32'h11223344, 16'h0008, "wr 0x20");
        recv(32'd0, 1'b0, "wr 0x20");
`ifdef BDRAM_CTRL_ALIGN_CHK_EN
        send(1'b0, 2'b01, 32'h21, 32'd0, 1'b0, 4'b0000, 32'd0, 16'h0008, "half misalign");
        recv(32'd0, 1'b1, "half misalign");
        send(1'b0, 2'b10, 32'h22, 32'd0, 1'b0, 4'b0000, 32'd0, 16'h0008, "word misalign");
        recv(32'd0, 1'b1, "word misalign");
`else
        send(1'b0, 2'b01, 32'h21, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0008, "half misalign");
        recv(32'h00003344, 1'b0, "half misalign");
        send(1'b0, 2'b10, 32'h22, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0008, "word misalign");
        recv(32'h11223344, 1'b0, "word misalign");
`endif

        // Reserved size
        send(1'b1, 2'b11, 32'h20, 32'hFFFFFFFF, 1'b0, 4'b0000, 32'd0, 16'h0008, "wr size11");
        recv(32'd0, 1'b1, "wr size11");
        send(1'b0, 2'b11, 32'h20, 32'd0, 1'b0, 4'b0000, 32'd0, 16'h0008, "rd size11");
        recv(32'd0, 1'b1, "rd size11");
        check(mem[8], 32'h11223344, "mem untouched by size11");

        // Reset while in WAIT
        send(1'b0, 2'b10, 32'h10, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0004, "rst mid");
        rst = 1'b1;
        #1;
        check({31'd0, rsp_valid}, 32'd0, "rst mid rsp_valid");
        check({30'd0, dbg_state}, 32'd0, "rst mid state");
        check({16'd0, ram_addr}, 32'd0, "rst mid ram_addr");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check({31'd0, rsp_valid}, 32'd0, "no rsp after rst");
        end
        send(1'b0, 2'b00, 32'h13, 32'd0, 1'b1, 4'b0000, 32'd0, 16'h0004, "rd after rst");
        recv(32'h000000A5, 1'b0, "rd after rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
